dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Initiator side of the data-memory port. Sits between the multicycle datapath and the word-addressed, single-port data memory.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Converts the byte address to a word index, performs byte/half/word loads with sign or zero extension, and implements sub-word stores as read-modify-write.
- Returns a one-cycle response pulse carrying load data or an error flag.

Parameters:
- ADDRESS_WIDTH, 32, width of the memory-side word index (Address port of data memory).
- DATA_WIDTH, 32, memory word width; fixed at 32 (byte lanes assume 4 bytes/word).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  synchronous active-low reset, sampled on posedge Clk.
- ReqValid  in  1  core presents a request.
- ReqReady  out  1  unit can accept a request (high only in IDLE).
- ReqWrite  in  1  1=store, 0=load.
- ReqSize  in  2  00=byte, 01=half, 10=word, 11=reserved.
- ReqSigned  in  1  loads: 1=sign-extend, 0=zero-extend; ignored for stores.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data; sub-word stores use the low bits.
- RespValid  out  1  one-cycle pulse: request complete.
- RespRData  out  32  load result; valid with RespValid; 0 for stores and errors.
- RespErr  out  1  misaligned or reserved-size request; valid with RespValid.
- MemAddress  out  ADDRESS_WIDTH  word index = ReqAddr[31:2], zero-extended or truncated to ADDRESS_WIDTH.
- MemWriteData  out  DATA_WIDTH  word to write.
- MemWrite  out  1  write strobe; memory writes on posedge while high.
- MemData  in  DATA_WIDTH  combinational read data for MemAddress.

Behaviour:
- Request capture: a handshake (ReqValid && ReqReady at posedge) latches ReqWrite, ReqSize, ReqSigned, ReqAddr and ReqWData. Request inputs are ignored in every other cycle.
- Byte lane = addr[1:0], little-endian: byte k occupies bits [8k+7:8k]. Half lane = addr[1]: bits [15:0] or [31:16].
- Error cases: size 11; half with addr[0]=1; word with addr[1:0]!=0. On error there is no memory access; go to RESP with RespErr=1.
- States:
  - IDLE: ReqReady=1. On handshake: error goes to RESP; load goes to RD; word store goes to WR; byte/half store goes to RMW_RD.
  - RD: drive MemAddress; capture the MemData lane, extended per ReqSigned, into the result register; go to RESP.
  - RMW_RD: drive MemAddress; capture MemData into the merge register; go to WR.
  - WR: drive MemAddress; MemWrite=1. MemWriteData = ReqWData for word stores, else the merge register with the target lane replaced by ReqWData[7:0] or [15:0]. Go to RESP.
  - RESP: RespValid=1 for exactly one cycle; go to IDLE. ReqReady=0 in this state.
- Latency from the handshake edge to the RespValid cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: back-to-back requests are accepted in IDLE immediately after RESP.
- MemWrite = (state==WR) && Rst_n. It is combinational so that no write occurs on an edge where reset is asserted.
- MemAddress and MemWriteData are held stable throughout RD, RMW_RD and WR; outside those states they are don't-care but driven, not X.
- Reset (Rst_n=0 at posedge), applied from any state including mid-RMW:
  - state=IDLE, RespValid=0, RespErr=0, RespRData=0.
  - Internal registers cleared; MemWrite low from that edge on.
  - An aborted RMW leaves memory unmodified.
- ReqReady reset value: 1 once in IDLE. It is 0 while Rst_n is low.

Decomposition:
- Shared package holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding localparams IDLE, RD, RMW_RD, WR, RESP (3-bit).
- Sub-module: lane_align (combinational). Provides load extract plus sign/zero extension, and store merge given {addr[1:0], size, signed}. It is reused by a future instruction-fetch path.

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10. Expect MemWrite high for one cycle with MemAddress=4, and RespRData=0xDEADBEEF two cycles after the load handshake.
- Sub-word RMW: memory word 4 = 0x11223344; store byte 0xAA to 0x12. Expect 3-cycle latency, written word 0x11AA3344, and exactly one MemWrite pulse.
- Load extension: word 4 = 0x80FF7F01.
  - Signed byte load at 0x11 gives 0x0000007F.
  - Signed half load at 0x12 gives 0xFFFF80FF.
  - Unsigned byte load at 0x13 gives 0x00000080.
- Errors: half load at 0x11, word store at 0x12, and size 11. Each gives RespValid and RespErr=1 one cycle after handshake, with no MemWrite and RespRData=0.
- Reset during WR of an RMW (Rst_n low in that cycle). Expect no memory write, memory word unchanged, no RespValid, and ReqReady=1 after Rst_n returns high.
- Back-to-back with ReqValid held high for 3 requests. Expect ReqReady low outside IDLE, each request accepted exactly once, and responses in order.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: size encodings and FSM states shared by the data-memory access unit.
package dmem_access_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;
endpackage

// File: rtl/lane_align.sv
// lane_align: little-endian load extract with sign/zero extension and sub-word store merge.
module lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [4:0]  w_bshift;
  logic [4:0]  w_hshift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  always_comb begin
    w_bshift = {i_lane, 3'b000};
    w_hshift = {i_lane[1], 4'b0000};
    w_byte   = 8'(i_rdata >> w_bshift);
    w_half   = 16'(i_rdata >> w_hshift);
    o_load   = i_size == SZ_BYTE ? {{24{i_signed & w_byte[7]}}, w_byte} :
               i_size == SZ_HALF ? {{16{i_signed & w_half[15]}}, w_half} : i_rdata;
    w_mask   = i_size == SZ_BYTE ? 32'h0000_00FF << w_bshift : 32'h0000_FFFF << w_hshift;
    w_ins    = i_size == SZ_BYTE ? {24'b0, i_wdata[7:0]} << w_bshift : {16'b0, i_wdata[15:0]} << w_hshift;
    o_merge  = i_size == SZ_WORD ? i_wdata : (i_rdata & ~w_mask) | (w_ins & w_mask);
  end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: one-at-a-time load/store initiator for a word-addressed single-port data memory.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [1:0]               ReqSize,
  input  logic                     ReqSigned,
  input  logic [31:0]              ReqAddr,
  input  logic [31:0]              ReqWData,
  output logic                     RespValid,
  output logic [31:0]              RespRData,
  output logic                     RespErr,
  output logic [ADDRESS_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0]    MemWriteData,
  output logic                     MemWrite,
  input  logic [DATA_WIDTH-1:0]    MemData
);
  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_signed;
  logic        r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        w_hs;
  logic        w_err;
  logic [31:0] w_src;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  assign ReqReady = r_state == IDLE && Rst_n;
  assign w_hs     = ReqValid && ReqReady;
  assign w_err    = ReqSize == 2'b11 || (ReqSize == SZ_HALF && ReqAddr[0]) ||
                    (ReqSize == SZ_WORD && ReqAddr[1:0] != 2'b00);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = w_err ? RESP : !ReqWrite ? RD : ReqSize == SZ_WORD ? WR : RMW_RD;
      RD:      w_next = RESP;
      RMW_RD:  w_next = WR;
      WR:      w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) r_state <= Rst_n ? w_next : IDLE;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_hs) begin
        r_write  <= ReqWrite;
        r_signed <= ReqSigned;
        r_size   <= ReqSize;
        r_addr   <= ReqAddr;
        r_wdata  <= ReqWData;
        r_err    <= w_err;
        r_rdata  <= '0;
      end
      if (r_state == RD) r_rdata <= w_load;
      if (r_state == RMW_RD) r_merge <= MemData;
    end
  end
  // Loads extract from live memory data; the write merge works on the word captured in RMW_RD.
  assign w_src = r_state == WR ? r_merge : MemData;
  lane_align u_lane (
    .i_lane   (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_rdata  (w_src),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );
  assign MemAddress   = ADDRESS_WIDTH'(r_addr[31:2]);
  assign MemWriteData = w_merge;
  assign MemWrite     = r_state == WR && Rst_n && r_write;
  assign RespValid    = r_state == RESP;
  assign RespErr      = r_err;
  assign RespRData    = r_rdata;
endmodule
